fifo_ctrl_8x16: RTL

FIFO_CTRL_8X16 -- requirements
Module: fifo_ctrl_8x16

---
 rtl/fifo_8x16_pkg.sv | 20 ++
 rtl/dual_port_ram_8x16.sv | 41 ++++
 rtl/fifo_ctrl_8x16.sv | 110 +++++++++++
 3 files changed

// File: rtl/fifo_8x16_pkg.sv
// Shared defaults for the 8x16 FIFO slice, with the pointer/count width derivation.
// Pointers and count both carry one bit more than the storage address.
package fifo_8x16_pkg;

  localparam int DEF_WIDTH     = 16;
  localparam int DEF_DEPTH     = 8;
  localparam int DEF_ADDR_W    = 3;
  localparam int DEF_AFULL_LVL = 6;

  // Pointer MSB is the wrap bit that tells full apart from empty
  function automatic int ptr_width(input int addr_w);
    return addr_w + 1;
  endfunction

  // Count must reach DEPTH itself, hence one extra bit
  function automatic int count_width(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/dual_port_ram_8x16.sv
// Simple dual-port RAM: one write port, one registered read port with a one-cycle read latency.
// The read register holds its value unless a read is enabled; the storage array itself is never cleared.
module dual_port_ram_8x16
  import fifo_8x16_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              re,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [WIDTH-1:0] rd_data_r;

  // Storage write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Registered read port, synchronously cleared by the active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_r <= '0;
    end else if (re) begin
      rd_data_r <= mem_r[rd_addr];
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/fifo_ctrl_8x16.sv
// Synchronous FIFO controller around dual_port_ram_8x16: wrap-bit pointers, occupancy count,
// registered status flags, sticky overflow/underflow and a one-cycle read-valid pipeline.
module fifo_ctrl_8x16
  import fifo_8x16_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int AFULL_LVL = DEF_AFULL_LVL
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  din,
  input  logic              rd_en,
  output logic [WIDTH-1:0]  dout,
  output logic              dout_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int PTR_W = ptr_width(ADDR_W);
  localparam int CNT_W = count_width(ADDR_W);

  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;
  logic             full_r;
  logic             empty_r;
  logic             almost_full_r;
  logic             dout_valid_r;
  logic             overflow_r;
  logic             underflow_r;
  logic             push_ok_s;
  logic             pop_ok_s;
  logic [WIDTH-1:0] ram_rd_data_s;

  // Acceptance uses only the flags registered on the previous edge
  assign push_ok_s = wr_en && !full_r;
  assign pop_ok_s  = rd_en && !empty_r;

  // Next occupancy; a simultaneous accepted push and pop leaves it unchanged
  always_comb begin
    count_nxt_s = count_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Controller state: pointers, count, flags derived from next count, sticky errors, read-valid
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_r      <= '0;
      rd_ptr_r      <= '0;
      count_r       <= '0;
      full_r        <= 1'b0;
      empty_r       <= 1'b1;
      almost_full_r <= 1'b0;
      dout_valid_r  <= 1'b0;
      overflow_r    <= 1'b0;
      underflow_r   <= 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r       <= count_nxt_s;
      full_r        <= (count_nxt_s == CNT_W'(DEPTH));
      empty_r       <= (count_nxt_s == CNT_W'(0));
      almost_full_r <= (count_nxt_s >= CNT_W'(AFULL_LVL));
      dout_valid_r  <= pop_ok_s;
      overflow_r    <= overflow_r | (wr_en && full_r);
      underflow_r   <= underflow_r | (rd_en && empty_r);
    end
  end

  dual_port_ram_8x16 #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst     (~rst),
    .we      (push_ok_s),
    .wr_addr (wr_ptr_r[ADDR_W-1:0]),
    .wr_data (din),
    .re      (pop_ok_s),
    .rd_addr (rd_ptr_r[ADDR_W-1:0]),
    .rd_data (ram_rd_data_s)
  );

  assign dout        = ram_rd_data_s;
  assign dout_valid  = dout_valid_r;
  assign full        = full_r;
  assign empty       = empty_r;
  assign almost_full = almost_full_r;
  assign count       = count_r;
  assign overflow    = overflow_r;
  assign underflow   = underflow_r;

endmodule
